// File: rtl/bp_stage_pkg.sv
// Shared branch-prediction definitions: default widths, reset PC and 2-bit counter encodings.
package bp_stage_pkg;

    localparam int          BP_ADDR_WIDTH      = 32;
    localparam int          BP_GHR_WIDTH       = 10;
    localparam int          BP_BTB_INDEX_WIDTH = 6;
    localparam logic [31:0] BP_RESET_PC        = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } cnt_t;

    // Saturating step: the two strong states absorb further moves in their own direction.
    function automatic cnt_t cnt_update(input cnt_t cnt, input logic taken);
        cnt_t res;
        res = cnt;
        case (cnt)
            STRONG_NT: res = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   res = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    res = taken ? STRONG_T : WEAK_NT;
            default:   res = taken ? STRONG_T : WEAK_T;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: 2-bit counters with one async-read port and one saturating-update port.
module bp_pht
    import bp_stage_pkg::*;
#(
    parameter int IDX_WIDTH = BP_GHR_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_WIDTH-1:0] rd_index,
    output cnt_t                 rd_cnt,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_index,
    input  logic                 wr_taken
);

    localparam int DEPTH = 1 << IDX_WIDTH;

    cnt_t cnt_q [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= WEAK_NT;
            end
        end else if (wr_en) begin
            cnt_q[wr_index] <= cnt_update(cnt_q[wr_index], wr_taken);
        end
    end

    // Read sees the pre-edge value, so a same-cycle update is not forwarded.
    assign rd_cnt = cnt_q[rd_index];

endmodule

// File: rtl/bp_stage.sv
// Branch-predict stage: fetch PC register, PHT + direct-mapped BTB lookup, execute-side training.
// Define BP_GSHARE_EN for gshare indexing (pc bits XOR global history); default is bimodal.
module bp_stage
    import bp_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = BP_ADDR_WIDTH,
    parameter int                    GHR_WIDTH       = BP_GHR_WIDTH,
    parameter int                    BTB_INDEX_WIDTH = BP_BTB_INDEX_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = BP_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  update_en,
    input  logic [ADDR_WIDTH-1:0] update_pc,
    input  logic [GHR_WIDTH-1:0]  update_pht_index,
    input  logic                  update_taken,
    input  logic [ADDR_WIDTH-1:0] update_target,
    output logic                  is_branch_taken,
    output logic [GHR_WIDTH-1:0]  current_pht_index,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic [ADDR_WIDTH-1:0] current_pc
);

    localparam int BTB_DEPTH = 1 << BTB_INDEX_WIDTH;
    localparam int TAG_WIDTH = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;

    logic [ADDR_WIDTH-1:0]      pc_q;
    logic [ADDR_WIDTH-1:0]      pc_plus4;
    logic [GHR_WIDTH-1:0]       lookup_index;
    cnt_t                       lookup_cnt;

    logic                       btb_valid_q  [BTB_DEPTH];
    logic [TAG_WIDTH-1:0]       btb_tag_q    [BTB_DEPTH];
    logic [ADDR_WIDTH-1:0]      btb_target_q [BTB_DEPTH];
    logic [BTB_INDEX_WIDTH-1:0] btb_rd_index;
    logic [BTB_INDEX_WIDTH-1:0] btb_wr_index;
    logic [TAG_WIDTH-1:0]       btb_rd_tag;
    logic [TAG_WIDTH-1:0]       btb_wr_tag;
    logic                       btb_hit;
    logic                       btb_write;
    logic                       predict_taken;
    logic                       unused_bits;

`ifdef BP_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_q;

    // History is built from resolved outcomes only, so it never needs repair on a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_q <= '0;
        end else if (update_en) begin
            ghr_q <= {ghr_q[GHR_WIDTH-2:0], update_taken};
        end
    end

    assign lookup_index = pc_q[GHR_WIDTH+1:2] ^ ghr_q;
`else
    assign lookup_index = pc_q[GHR_WIDTH+1:2];
`endif

    bp_pht #(
        .IDX_WIDTH (GHR_WIDTH)
    ) u_pht (
        .clk      (clk),
        .rst      (rst),
        .rd_index (lookup_index),
        .rd_cnt   (lookup_cnt),
        .wr_en    (update_en),
        .wr_index (update_pht_index),
        .wr_taken (update_taken)
    );

    assign btb_rd_index = pc_q[BTB_INDEX_WIDTH+1:2];
    assign btb_rd_tag   = pc_q[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
    assign btb_wr_index = update_pc[BTB_INDEX_WIDTH+1:2];
    assign btb_wr_tag   = update_pc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
    assign btb_write    = update_en && update_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_valid_q[i] <= 1'b0;
            end
        end else if (btb_write) begin
            btb_valid_q[btb_wr_index] <= 1'b1;
        end
    end

    // Tag and target are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (btb_write) begin
            btb_tag_q[btb_wr_index]    <= btb_wr_tag;
            btb_target_q[btb_wr_index] <= update_target;
        end
    end

    assign btb_hit       = btb_valid_q[btb_rd_index] && (btb_tag_q[btb_rd_index] == btb_rd_tag);
    assign predict_taken = btb_hit && lookup_cnt[1];
    assign pc_plus4      = pc_q + ADDR_WIDTH'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (flush) begin
            pc_q <= flush_pc;
        end else if (!stall) begin
            pc_q <= next_pc;
        end
    end

    assign is_branch_taken   = predict_taken;
    assign current_pht_index = lookup_index;
    assign next_pc           = predict_taken ? btb_target_q[btb_rd_index] : pc_plus4;
    assign current_pc        = pc_q;

    assign unused_bits = ^{update_pc[1:0], lookup_cnt[0]};

endmodule

// File: tb/tb_bp_stage.sv
// Directed bench for bp_stage (default bimodal build); expectations go to a queue checked by a monitor.
module tb_bp_stage;

  localparam logic [31:0] R = 32'hbfc0_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic [9:0]  update_pht_index;
  logic        update_taken;
  logic [31:0] update_target;
  logic        is_branch_taken;
  logic [9:0]  current_pht_index;
  logic [31:0] next_pc;
  logic [31:0] current_pc;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        taken;
    logic [9:0]  idx;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    tk_seq   [11];
  bit    pred_seq [11];

  bp_stage dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_pht_index  (update_pht_index),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .is_branch_taken   (is_branch_taken),
    .current_pht_index (current_pht_index),
    .next_pc           (next_pc),
    .current_pc        (current_pc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_update(input logic [31:0] pc, input logic [9:0] idx,
                            input logic tk, input logic [31:0] tgt);
    update_en        = 1'b1;
    update_pc        = pc;
    update_pht_index = idx;
    update_taken     = tk;
    update_target    = tgt;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] pc,
                            input logic [31:0] npc, input logic tk);
    exp_t e;
    e.pc    = pc;
    e.npc   = npc;
    e.taken = tk;
    e.idx   = pc[11:2];
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // scoreboard
  task automatic check_field(input string nm, input string fld,
                             input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check_field(nm, "current_pc", current_pc, e.pc);
      check_field(nm, "next_pc", next_pc, e.npc);
      check_field(nm, "is_branch_taken", {31'd0, is_branch_taken}, {31'd0, e.taken});
      check_field(nm, "current_pht_index", {22'd0, current_pht_index}, {22'd0, e.idx});
    end
  end

  // stimulus
  initial begin
    tk_seq   = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    pred_seq = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    rst = 1'b0; stall = 1'b0; flush = 1'b0; flush_pc = '0;
    update_en = 1'b0; update_pc = '0; update_pht_index = '0;
    update_taken = 1'b0; update_target = '0;

    cyc(); cyc();
    expect_out("reset_hold", R, R + 4, 1'b0);
    cyc(); rst = 1'b1;
    expect_out("reset_release", R, R + 4, 1'b0);
    cyc(); expect_out("seq_pc4", R + 4, R + 8, 1'b0);
    cyc(); expect_out("seq_pc8", R + 8, R + 12, 1'b0);

    // two taken updates for R+0x10 while the PC is parked
    stall = 1'b1;
    set_update(R + 32'h10, 10'd4, 1'b1, R + 32'h100);
    cyc(); expect_out("stall_train1", R + 8, R + 12, 1'b0);
    cyc(); expect_out("stall_train2", R + 8, R + 12, 1'b0);
    stall = 1'b0; update_en = 1'b0;
    cyc(); expect_out("seq_pc12", R + 12, R + 16, 1'b0);
    cyc(); expect_out("btb_hit", R + 32'h10, R + 32'h100, 1'b1);
    cyc(); expect_out("redirect", R + 32'h100, R + 32'h104, 1'b0);

    // saturation on index 0x40; each expectation is also the same-cycle view of the next update
    stall = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_update(R + 32'h100, 10'h40, tk_seq[i], R + 32'h200);
      cyc();
      expect_out($sformatf("sat_%0d", i), R + 32'h100,
                 pred_seq[i] ? R + 32'h200 : R + 32'h104, pred_seq[i]);
    end
    update_en = 1'b0;

    // stall with flush in the middle; flush-cycle update still trains
    cyc(); expect_out("stall_hold", R + 32'h100, R + 32'h200, 1'b1);
    flush = 1'b1; flush_pc = 32'h8000_0000;
    set_update(32'h8000_0000, 10'd0, 1'b1, 32'h8000_0040);
    cyc(); flush = 1'b0; update_en = 1'b0;
    expect_out("flush_over_stall", 32'h8000_0000, 32'h8000_0040, 1'b1);
    cyc(); expect_out("stall_after_flush", 32'h8000_0000, 32'h8000_0040, 1'b1);
    stall = 1'b0;
    cyc(); expect_out("flush_predicted", 32'h8000_0040, 32'h8000_0044, 1'b0);

    // address wrap and BTB tag mismatch at index 0
    flush = 1'b1; flush_pc = 32'hffff_fffc;
    cyc(); flush = 1'b0;
    expect_out("wrap_pc", 32'hffff_fffc, 32'h0000_0000, 1'b0);
    cyc(); expect_out("wrap_zero_tag_miss", 32'h0000_0000, 32'h0000_0004, 1'b0);
    cyc(); expect_out("pre_reset", 32'h0000_0004, 32'h0000_0008, 1'b0);
    @(negedge clk); #1;

    // asynchronous reset: checked before any rising edge sees it
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    expect_out("async_reset", R, R + 4, 1'b0);
    cyc(); rst = 1'b1;
    expect_out("reset_release2", R, R + 4, 1'b0);
    cyc(); expect_out("post_rst_pc4", R + 4, R + 8, 1'b0);
    cyc(); expect_out("post_rst_pc8", R + 8, R + 12, 1'b0);
    cyc(); expect_out("post_rst_pc12", R + 12, R + 16, 1'b0);
    cyc(); expect_out("btb_cleared", R + 16, R + 20, 1'b0);
    stall = 1'b1;
    set_update(R + 16, 10'd4, 1'b1, R + 32'h100);
    cyc(); expect_out("pht_reset_inc", R + 16, R + 32'h100, 1'b1);
    set_update(R + 16, 10'd4, 1'b0, 32'h0);
    cyc(); update_en = 1'b0;
    expect_out("pht_reset_dec", R + 16, R + 20, 1'b0);

    cyc();
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_stage.md
# bp_stage

Branch-predict (BP) stage at the head of the front end, directly upstream of the BP/IF pipeline register. Holds the architectural fetch PC and produces, each cycle, the current PC, the predicted next PC, the taken prediction and the PHT index used, all consumed by the BP/IF register. Prediction uses a gshare PHT of 2-bit counters plus a direct-mapped BTB; both are trained by resolved-branch updates from the execute stage.

## Interface
- ADDR_WIDTH, 32, address width
- GHR_WIDTH, 10, history length and PHT index width (PHT has 2^GHR_WIDTH entries)
- BTB_INDEX_WIDTH, 6, BTB has 2^BTB_INDEX_WIDTH entries
- RESET_PC, 32'hbfc0_0000, PC after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and outputs (stall_current_stage of BP)
- flush  in  1  redirect from later stage
- flush_pc  in  ADDR_WIDTH  redirect target
- update_en  in  1  resolved branch valid
- update_pc  in  ADDR_WIDTH  PC of resolved branch
- update_pht_index  in  GHR_WIDTH  index carried down the pipe with the branch
- update_taken  in  1  actual direction
- update_target  in  ADDR_WIDTH  actual taken target
- is_branch_taken  out  1  prediction for current_pc
- current_pht_index  out  GHR_WIDTH  index used for lookup
- next_pc  out  ADDR_WIDTH  predicted successor
- current_pc  out  ADDR_WIDTH  PC being fetched

## Operation
- State: pc register, ghr (GHR_WIDTH), PHT (2-bit counters), BTB (valid, tag = pc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2], target).
- Lookup (combinational from pc): idx = pc[GHR_WIDTH+1:2] ^ ghr; btb_hit = valid & tag match at pc[BTB_INDEX_WIDTH+1:2]; is_branch_taken = btb_hit & pht[idx][1]; next_pc = is_branch_taken ? btb_target : pc + 4 (modulo 2^ADDR_WIDTH).
- current_pc = pc; current_pht_index = idx.
- PC update priority: flush (pc <= flush_pc) > stall (hold) > advance (pc <= next_pc).
- Training on update_en: pht[update_pht_index] saturating inc if update_taken else saturating dec (00 and 11 stick); ghr <= {ghr[GHR_WIDTH-2:0], update_taken} (non-speculative history); if update_taken, BTB entry of update_pc <= {valid=1, tag, update_target}. Not-taken updates leave BTB untouched.
- Training is independent of stall and flush; an update arriving with flush still applies.

## Timing
- Reset values: pc = RESET_PC, ghr = 0, all PHT = 2'b01 (weakly not-taken), all BTB valid = 0. Hence outputs after reset: current_pc = RESET_PC, next_pc = RESET_PC + 4, is_branch_taken = 0, current_pht_index = RESET_PC[GHR_WIDTH+1:2].
- Outputs are combinational from registered state; zero-cycle lookup, the BP/IF register provides the stage boundary.
- Update written at edge N visible to lookup from cycle N+1; same-cycle lookup of the same PHT/BTB entry returns the old value.
- Flush at edge N: current_pc = flush_pc in cycle N+1.
- Reset asserted mid-operation returns all state to reset values immediately, independent of clk.

## Configuration
- BP_GSHARE_EN defined: index = pc bits XOR ghr as above.
- Undefined: bimodal; idx = pc[GHR_WIDTH+1:2], ghr register not instantiated (reads as 0), update still uses update_pht_index.

## Structure
- Shared branch package/header: GHR_WIDTH, counter encodings (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11), ADDR_WIDTH, RESET_PC.
- One sub-module, bp_pht: counter array with one async-read port and one saturating-update port, reset to WEAK_NT.

## Test plan
- Reset release, no updates -> current_pc 32'hbfc0_0000, then 32'hbfc0_0004, 32'hbfc0_0008 on successive cycles, is_branch_taken 0 throughout.
- Two taken updates for pc 32'hbfc0_0010 target 32'hbfc0_0100 (bimodal build) -> when pc reaches 32'hbfc0_0010, is_branch_taken 1, next_pc 32'hbfc0_0100, following current_pc 32'hbfc0_0100.
- Counter saturation: five taken then one not-taken on same index -> counter 11 then 10, prediction stays taken; three more not-taken -> 00, not-taken.
- stall held 3 cycles with flush asserted in cycle 2, flush_pc 32'h8000_0000 -> current_pc 32'h8000_0000 the cycle after flush regardless of stall.
- Simultaneous update and lookup of same PHT entry -> lookup returns pre-update value, new value visible next cycle.
- Async reset pulse mid-run after training -> PC RESET_PC, BTB invalid, PHT 01, ghr 0 without a clock edge.
